// File: rtl/regfile_pkg.sv
// Shared constants and types for the one-hot register file.
package regfile_pkg;

   localparam int XZR_IDX       = 31;
   localparam int NREGS_DEFAULT = 32;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_A    = 2'd1,
      ERR_B    = 2'd2,
      ERR_D    = 2'd3
   } err_src_t;

endpackage

// File: rtl/regfile_onehot_encoder.sv
// One-hot to binary encoder with zero-hot / multi-hot detection.
module onehot_encoder
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic [NREGS-1:0] vec,
   output logic [4:0]       idx,
   output logic             zero,
   output logic             multi
);

   localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      idx = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (vec[i]) idx = idx | i[4:0];
      end
   end

   assign zero  = (vec == '0);
   // Clearing the lowest set bit leaves something behind only when two or more bits are set.
   assign multi = ((vec & (vec - ONE)) != '0);

endmodule

// File: rtl/regfile_onehot.sv
// One-hot addressed 2R1W register file with XZR and a sticky select-error flag.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module regfile_onehot
   import regfile_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREGS-1:0] Aselect,
   input  logic [NREGS-1:0] Bselect,
   input  logic [NREGS-1:0] Dselect,
   input  logic [WIDTH-1:0] dbus,
   output logic [WIDTH-1:0] abus,
   output logic [WIDTH-1:0] bbus,
   output logic             sel_err,
   output logic [1:0]       err_src
);

   logic [WIDTH-1:0] regs [NREGS-1];

   logic [4:0] a_idx, b_idx, d_idx;
   logic       a_zero, b_zero, d_zero;
   logic       a_multi, b_multi, d_multi;
   logic       a_ok, b_ok, d_ok;
   err_src_t   err_q;

   onehot_encoder #(.NREGS(NREGS)) u_enc_a (.vec(Aselect), .idx(a_idx), .zero(a_zero), .multi(a_multi));
   onehot_encoder #(.NREGS(NREGS)) u_enc_b (.vec(Bselect), .idx(b_idx), .zero(b_zero), .multi(b_multi));
   onehot_encoder #(.NREGS(NREGS)) u_enc_d (.vec(Dselect), .idx(d_idx), .zero(d_zero), .multi(d_multi));

   // A port is "ok" only for a legal one-hot select that points at real storage.
   assign a_ok = !a_zero && !a_multi && (a_idx != 5'(XZR_IDX));
   assign b_ok = !b_zero && !b_multi && (b_idx != 5'(XZR_IDX));
   assign d_ok = !d_zero && !d_multi && (d_idx != 5'(XZR_IDX));

   always_comb begin
      abus = '0;
      bbus = '0;
      for (int i = 0; i < NREGS - 1; i++) begin
         if (a_ok && a_idx == i[4:0]) abus = regs[i];
         if (b_ok && b_idx == i[4:0]) bbus = regs[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (d_ok && !reset && a_ok && a_idx == d_idx) abus = dbus;
      if (d_ok && !reset && b_ok && b_idx == d_idx) bbus = dbus;
`endif
   end

   // NOTE: the array is cleared by the async reset because registers must read 0 during reset;
   // storage arrays that need no defined contents are normally left unreset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
      end else if (d_ok) begin
         for (int i = 0; i < NREGS - 1; i++) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (d_idx == i[4:0]) regs[i] <= dbus;
         end
      end
   end

   // First illegal select wins; priority A, then B, then D.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_err <= 1'b0;
         err_q   <= ERR_NONE;
      end else if (!sel_err) begin
         if (a_zero || a_multi) begin
            sel_err <= 1'b1;
            err_q   <= ERR_A;
         end else if (b_zero || b_multi) begin
            sel_err <= 1'b1;
            err_q   <= ERR_B;
         end else if (d_multi) begin
            sel_err <= 1'b1;
            err_q   <= ERR_D;
         end
      end
   end

   assign err_src = err_q;

endmodule
